// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master peripheral bus arbiter.
// State encoding, default timeout read data and the size-select codes used by the bus decoder.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [1:0] SEL_BYTE = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_WORD = 2'b10;

endpackage

// File: rtl/bus_watchdog.sv
// Transaction watchdog: counts stalled granted cycles and flags the last allowed cycle.
// A TIMEOUT of 0 keeps expire low permanently.
module bus_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Expire on the final waiting cycle so the error response replaces the would-be next wait.
  assign expire = (TIMEOUT > 0) && (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin two-master arbiter for the 32-bit peripheral bus; grant held until slave ack
// or watchdog expiry, which returns ERR_DATA with a one-cycle err_o pulse.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 8,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_rd_i,
  input  logic        m0_we_i,
  output logic        m0_ack_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_rd_i,
  input  logic        m1_we_i,
  output logic        m1_ack_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  output logic [1:0]  s_sel_o,
  output logic        s_rd_o,
  output logic        s_we_o,
  input  logic        s_ack_i,
  output logic        busy_o,
  output logic        err_o,
  output logic        err_id_o
);

  arb_state_t  state, state_nxt;
  logic        last, last_nxt;
  logic        req0, req1;
  logic        granted, gnt_id;
  logic        expire;
  logic        rsp_ack;
  logic [31:0] rsp_data;

  assign req0    = m0_rd_i | m0_we_i;
  assign req1    = m1_rd_i | m1_we_i;
  assign granted = (state == GRANT0) || (state == GRANT1);
  assign gnt_id  = (state == GRANT1);

  bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (!granted),
    .en     (granted && !s_ack_i),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    s_addr_o  = '0;
    s_data_o  = '0;
    s_sel_o   = '0;
    s_rd_o    = 1'b0;
    s_we_o    = 1'b0;
    busy_o    = 1'b0;
    err_o     = 1'b0;
    err_id_o  = 1'b0;
    rsp_ack   = 1'b0;
    rsp_data  = '0;
    m0_ack_o  = 1'b0;
    m0_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_data_o = '0;

    case (state)
      IDLE: begin
        // Under contention the master not granted last time wins.
        if (req0 && (!req1 || last)) begin
          state_nxt = GRANT0;
          last_nxt  = 1'b0;
        end else if (req1) begin
          state_nxt = GRANT1;
          last_nxt  = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        busy_o = 1'b1;
        if (gnt_id) begin
          s_addr_o = m1_addr_i;
          s_data_o = m1_data_i;
          s_sel_o  = m1_sel_i;
          s_rd_o   = m1_rd_i;
          s_we_o   = m1_we_i;
        end else begin
          s_addr_o = m0_addr_i;
          s_data_o = m0_data_i;
          s_sel_o  = m0_sel_i;
          s_rd_o   = m0_rd_i;
          s_we_o   = m0_we_i;
        end
        rsp_ack  = s_ack_i;
        rsp_data = s_data_i;
        if (s_ack_i) begin
          state_nxt = IDLE;
        end else if (expire) begin
          s_rd_o    = 1'b0;
          s_we_o    = 1'b0;
          rsp_ack   = 1'b1;
          rsp_data  = ERR_DATA;
          err_o     = 1'b1;
          err_id_o  = gnt_id;
          state_nxt = IDLE;
        end
        if (gnt_id) begin
          m1_ack_o  = rsp_ack;
          m1_data_o = rsp_data;
        end else begin
          m0_ack_o  = rsp_ack;
          m0_data_o = rsp_data;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a response scoreboard: expected completions are
// queued when a request is driven and compared when the matching ack appears.
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] m0_addr_i = '0, m0_data_i = '0, m0_data_o;
  logic [1:0]  m0_sel_i = '0;
  logic        m0_rd_i = 1'b0, m0_we_i = 1'b0, m0_ack_o;
  logic [31:0] m1_addr_i = '0, m1_data_i = '0, m1_data_o;
  logic [1:0]  m1_sel_i = '0;
  logic        m1_rd_i = 1'b0, m1_we_i = 1'b0, m1_ack_o;
  logic [31:0] s_addr_o, s_data_o;
  logic [31:0] s_data_i = '0;
  logic [1:0]  s_sel_o;
  logic        s_rd_o, s_we_o;
  logic        s_ack_i = 1'b0;
  logic        busy_o, err_o, err_id_o;

  int checks = 0;
  int errors = 0;
  bit model_last;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
    logic        data_valid;
  } exp_t;

  exp_t sb[$];

  bus_arbiter #(
    .TIMEOUT  (TO),
    .CNT_W    (8),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .m0_addr_i (m0_addr_i),
    .m0_data_i (m0_data_i),
    .m0_data_o (m0_data_o),
    .m0_sel_i  (m0_sel_i),
    .m0_rd_i   (m0_rd_i),
    .m0_we_i   (m0_we_i),
    .m0_ack_o  (m0_ack_o),
    .m1_addr_i (m1_addr_i),
    .m1_data_i (m1_data_i),
    .m1_data_o (m1_data_o),
    .m1_sel_i  (m1_sel_i),
    .m1_rd_i   (m1_rd_i),
    .m1_we_i   (m1_we_i),
    .m1_ack_o  (m1_ack_o),
    .s_addr_o  (s_addr_o),
    .s_data_o  (s_data_o),
    .s_data_i  (s_data_i),
    .s_sel_o   (s_sel_o),
    .s_rd_o    (s_rd_o),
    .s_we_o    (s_we_o),
    .s_ack_i   (s_ack_i),
    .busy_o    (busy_o),
    .err_o     (err_o),
    .err_id_o  (err_id_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit id, input logic rd, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] sel);
    if (id) begin
      m1_rd_i = rd; m1_we_i = we; m1_addr_i = addr; m1_data_i = wdata; m1_sel_i = sel;
    end else begin
      m0_rd_i = rd; m0_we_i = we; m0_addr_i = addr; m0_data_i = wdata; m0_sel_i = sel;
    end
  endtask

  task automatic check_rsp(input exp_t e);
    chk("ack_hit", 32'(e.id ? m1_ack_o : m0_ack_o), 32'd1);
    chk("ack_other", 32'(e.id ? m0_ack_o : m1_ack_o), 32'd0);
    if (e.data_valid) chk("rdata", e.id ? m1_data_o : m0_data_o, e.data);
    chk("err", 32'(err_o), 32'(e.err));
    if (e.err) chk("err_id", 32'(err_id_o), 32'(e.id));
  endtask

  // One transaction from an idle bus; ack_at is the granted cycle carrying s_ack_i (0 = never).
  task automatic do_txn(input bit id, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] sel, input int ack_at, input logic [31:0] rdata);
    exp_t e;
    int   exp_c;
    bit   seen;
    logic ack_t;
    tick;
    drive(id, !wr, wr, addr, wdata, sel);
    s_ack_i  = 1'b0;
    s_data_i = rdata;
    #1;
    chk("req_cycle_strobes", 32'({s_rd_o, s_we_o}), 32'd0);
    chk("req_cycle_busy", 32'(busy_o), 32'd0);
    if (ack_at > 0 && ack_at <= TO) begin
      exp_c = ack_at;
      e = '{id, rdata, 1'b0, !wr};
    end else begin
      exp_c = TO;
      e = '{id, 32'hDEAD_BEEF, 1'b1, 1'b1};
    end
    sb.push_back(e);
    seen = 1'b0;
    for (int c = 1; c <= TO + 4 && !seen; c++) begin
      tick;
      s_ack_i = (c == ack_at);
      #1;
      if (c == 1) begin
        chk("grant_rd", 32'(s_rd_o), 32'(!wr));
        chk("grant_we", 32'(s_we_o), 32'(wr));
        chk("grant_addr", s_addr_o, addr);
        chk("grant_sel", 32'(s_sel_o), 32'(sel));
        chk("grant_busy", 32'(busy_o), 32'd1);
        if (wr) chk("grant_wdata", s_data_o, wdata);
      end
      ack_t = id ? m1_ack_o : m0_ack_o;
      if (ack_t || c >= exp_c) begin
        seen = 1'b1;
        chk("ack_cycle", 32'(c), 32'(exp_c));
        if (sb.size() > 0) check_rsp(sb.pop_front());
        if (e.err) chk("timeout_strobes", 32'({s_rd_o, s_we_o}), 32'd0);
      end else begin
        chk("wait_other_ack", 32'(id ? m0_ack_o : m1_ack_o), 32'd0);
        chk("wait_err", 32'(err_o), 32'd0);
      end
    end
    tick;
    drive(id, 1'b0, 1'b0, '0, '0, '0);
    s_ack_i = e.err;
    #1;
    chk("after_acks", 32'({m0_ack_o, m1_ack_o}), 32'd0);
    chk("after_busy", 32'(busy_o), 32'd0);
    s_ack_i = 1'b0;
  endtask

  task automatic contention(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      tick;
      drive(1'b0, 1'b1, 1'b0, 32'h0000_0100, '0, SEL_WORD);
      drive(1'b1, 1'b1, 1'b0, 32'h0000_0200, '0, SEL_WORD);
      s_ack_i = 1'b0;
      #1;
      chk("cont_idle_busy", 32'(busy_o), 32'd0);
      e.id = !model_last;
      model_last = e.id;
      e.data = 32'hA000_0000 + 32'(k);
      e.err = 1'b0;
      e.data_valid = 1'b1;
      sb.push_back(e);
      tick;
      #1;
      chk("cont_grant_addr", s_addr_o, e.id ? 32'h0000_0200 : 32'h0000_0100);
      tick;
      s_ack_i  = 1'b1;
      s_data_i = e.data;
      #1;
      if (sb.size() > 0) check_rsp(sb.pop_front());
    end
    tick;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    s_ack_i = 1'b0;
    #1;
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_strobes", 32'({s_rd_o, s_we_o}), 32'd0);
    chk("rst_addr", s_addr_o, 32'd0);
    chk("rst_wdata", s_data_o, 32'd0);
    chk("rst_sel", 32'(s_sel_o), 32'd0);
    chk("rst_acks", 32'({m0_ack_o, m1_ack_o}), 32'd0);
    chk("rst_err", 32'({err_o, err_id_o}), 32'd0);
    chk("rst_m0_data", m0_data_o, 32'd0);
    chk("rst_m1_data", m1_data_o, 32'd0);
    tick;
    rstn = 1'b1;
    model_last = 1'b1;

    contention(4);
    do_txn(1'b0, 1'b0, 32'h0000_1000, '0, SEL_WORD, 3, 32'h1234_5678);
    do_txn(1'b1, 1'b1, 32'h0002_0004, 32'hCAFE_0001, 2'b10, 2, 32'h0BAD_F00D);
    do_txn(1'b0, 1'b0, 32'h0000_3000, '0, SEL_BYTE, 0, 32'h1111_2222);
    do_txn(1'b1, 1'b0, 32'h0000_4000, '0, SEL_HALF, TO, 32'h55AA_1234);
    do_txn(1'b1, 1'b0, 32'h0000_4400, '0, SEL_WORD, 0, 32'h3333_4444);

    tick;
    drive(1'b1, 1'b1, 1'b0, 32'h0000_5000, '0, SEL_WORD);
    #1;
    tick;
    #1;
    chk("prerst_busy", 32'(busy_o), 32'd1);
    chk("prerst_rd", 32'(s_rd_o), 32'd1);
    #1;
    rstn    = 1'b0;
    s_ack_i = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_strobes", 32'({s_rd_o, s_we_o}), 32'd0);
    chk("midrst_addr", s_addr_o, 32'd0);
    chk("midrst_m1_ack", 32'(m1_ack_o), 32'd0);
    chk("midrst_m1_data", m1_data_o, 32'd0);
    tick;
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    s_ack_i = 1'b0;
    tick;
    rstn = 1'b1;
    model_last = 1'b1;
    contention(2);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
